// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: allocates four synth voices from a stream of decoded MIDI
// channel messages.
//   clk, rst_n          clock and asynchronous active-low reset
//   ch_message, chan    status nibble (non-zero for one cycle per message) and channel
//   note, velocity, lsb message data bytes
//   gate, retrig        per-voice gate and one-cycle allocation pulse
//   voice_note/vel      per-voice note and velocity, voice i on bits [7i+6:7i]
//   all_busy            all four voices gated
// Every output is registered, so a message seen in cycle N shows up in cycle N+1.

// One voice slot: holds gate, note, velocity, LRU age and the retrig pulse.
module midi_voice_slot #(
  parameter int AW      = 2,
  parameter int RST_AGE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc_i,   // this voice takes the incoming note-on
  input  logic          bump_i,    // another voice was allocated and this one ages
  input  logic          clr_i,     // note-off hit or all-notes-off
  input  logic [6:0]    note_i,
  input  logic [6:0]    vel_i,
  output logic          gate_d_o,
  output logic          gate_o,
  output logic          retrig_o,
  output logic [6:0]    note_o,
  output logic [6:0]    vel_o,
  output logic [AW-1:0] age_o
);
  logic          gate_q, retrig_q;
  logic [6:0]    note_q, vel_q;
  logic [AW-1:0] age_q;

  // Allocation wins over clear; the two never coincide for a single message.
  assign gate_d_o = alloc_i ? 1'b1 : (clr_i ? 1'b0 : gate_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q   <= 1'b0;
      retrig_q <= 1'b0;
      note_q   <= '0;
      vel_q    <= '0;
      age_q    <= AW'(RST_AGE);
    end else begin
      gate_q   <= gate_d_o;
      retrig_q <= alloc_i;
      if (alloc_i) begin
        note_q <= note_i;
        vel_q  <= vel_i;
        age_q  <= '0;
      end else if (bump_i) begin
        age_q  <= age_q + AW'(1);
      end
    end
  end

  assign gate_o   = gate_q;
  assign retrig_o = retrig_q;
  assign note_o   = note_q;
  assign vel_o    = vel_q;
  assign age_o    = age_q;
endmodule

module midi_voice_alloc #(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  ch_message,
  input  logic [3:0]  chan,
  input  logic [6:0]  note,
  input  logic [6:0]  velocity,
  input  logic [6:0]  lsb,
  output logic [3:0]  gate,
  output logic [3:0]  retrig,
  output logic [27:0] voice_note,
  output logic [27:0] voice_vel,
  output logic        all_busy
);
  localparam int NV = 4;
  localparam int AW = $clog2(NV);

  logic                   accept, note_on, note_off, all_off;
  logic [NV-1:0]          gate_q, gate_d, hit, alloc, bump, clr;
  logic [NV-1:0][6:0]     vnote, vvel;
  logic [NV-1:0][AW-1:0]  age;
  logic [AW-1:0]          hit_idx, free_idx, old_idx, sel_idx, best_age, prev_age;
  logic                   all_busy_q;

  assign accept   = OMNI || (chan == CHANNEL);
  assign note_on  = accept && (ch_message == 4'b1001) && (velocity != 7'd0);
  assign note_off = accept && ((ch_message == 4'b1000) ||
                               ((ch_message == 4'b1001) && (velocity == 7'd0)));
  assign all_off  = accept && (ch_message == 4'b1011) && (lsb == 7'd123);

  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    old_idx  = '0;
    best_age = '0;
    for (int i = 0; i < NV; i++) hit[i] = gate_q[i] && (vnote[i] == note);
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = NV-1; i >= 0; i--) if (hit[i]) hit_idx = AW'(i);
    // Ages are a permutation, so the free-voice maximum is unique.
    for (int i = 0; i < NV; i++) begin
      if (!gate_q[i] && (age[i] >= best_age)) begin
        best_age = age[i];
        free_idx = AW'(i);
      end
      if (age[i] == AW'(NV-1)) old_idx = AW'(i);
    end
    if (|hit)         sel_idx = hit_idx;
    else if (~&gate_q) sel_idx = free_idx;
    else              sel_idx = old_idx;
    prev_age = age[sel_idx];
    alloc    = note_on ? (NV'(1) << sel_idx) : '0;
    for (int i = 0; i < NV; i++) begin
      bump[i] = note_on && !alloc[i] && (age[i] < prev_age);
      clr[i]  = (note_off && hit[i]) || all_off;
    end
  end

  for (genvar g = 0; g < NV; g++) begin : g_voice
    midi_voice_slot #(.AW(AW), .RST_AGE(NV-1-g)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .alloc_i  (alloc[g]),
      .bump_i   (bump[g]),
      .clr_i    (clr[g]),
      .note_i   (note),
      .vel_i    (velocity),
      .gate_d_o (gate_d[g]),
      .gate_o   (gate_q[g]),
      .retrig_o (retrig[g]),
      .note_o   (vnote[g]),
      .vel_o    (vvel[g]),
      .age_o    (age[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) all_busy_q <= 1'b0;
    else        all_busy_q <= &gate_d;
  end

  assign gate       = gate_q;
  assign voice_note = vnote;
  assign voice_vel  = vvel;
  assign all_busy   = all_busy_q;
endmodule
